// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the fetch stage's instruction-memory port, the
// execute redirect input and the decode-side handshake.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where the producer's valid/req and the consumer's ready/gnt are both high.
// The producer holds its payload stable while valid is high and ready is low.
// The redirect channel has no back-pressure; redirect_valid is always taken.
//
// Modports:
//   master - the fetch stage (drives imem_req/imem_addr and if_valid/if_instr/
//            if_pc/if_opcode; receives gnt, rvalid, rdata, redirect, if_ready)
//   slave  - the environment: instruction memory, execute and decode
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [6:0]      if_opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_opcode,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_opcode,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the main decoder/controller.
// Holds the PC, issues word fetches (one outstanding at most), buffers the
// returned words in a small FIFO and presents {instr, pc} to decode. A
// redirect from execute flushes the buffer and restarts fetch at the target;
// a response still in flight at that point is dropped when it returns.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        instr_fetch_if.master (imem_*, redirect_*, if_*)
//   dbg_state  current FSM state (0 RESET_HOLD, 1 RUN, 2 DRAIN)
//   perf_fetched/perf_stall/perf_flush  only when FETCH_PERF_CNT_EN is
//              defined: words pushed, cycles with if_ready & ~if_valid,
//              redirects taken; all wrap and reset to 0.
//
// Parameters: XLEN (address width), RESET_PC (first fetch address),
// FIFO_DEPTH (buffer entries, power of 2, >= 2).
module instr_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_if.master       bus,
  output logic [1:0]          dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall,
  output logic [31:0]         perf_flush
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_DRAIN      = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;       // address of the request in flight
  logic            outstanding_q;

  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            discard;
  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            room;
  logic            req;
  logic            grant;
  logic [CW:0]     occupancy;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET_HOLD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET_HOLD: state_d = S_RUN;
      // Redirect while the granted request has not answered: its response
      // belongs to the old path and must be dropped on arrival.
      S_RUN:        if (bus.redirect_valid && outstanding_q && !bus.imem_rvalid)
                      state_d = S_DRAIN;
      // The stale response arrives (a coincident redirect changes nothing:
      // the stale word is dropped either way and nothing is left in flight).
      S_DRAIN:      if (bus.imem_rvalid) state_d = S_RUN;
      default:      state_d = S_RESET_HOLD;
    endcase
  end

  assign discard   = (state_q == S_DRAIN);
  assign dbg_state = state_q;

  // ------------------------------------------------------ request issue
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && bus.if_ready && !bus.redirect_valid;
  assign push       = bus.imem_rvalid && outstanding_q && !discard && !bus.redirect_valid;

  // Reserve a FIFO slot for the word in flight so a full buffer never has
  // to refuse a response; a pop this cycle frees one slot early.
  assign occupancy = {1'b0, count_q} + (CW+1)'(outstanding_q) - (CW+1)'(pop);
  assign room      = (occupancy < (CW+1)'(FIFO_DEPTH));

  // A new request may go out in the same cycle its predecessor returns.
  assign req   = (state_q != S_RESET_HOLD) && !bus.redirect_valid &&
                 (!outstanding_q || bus.imem_rvalid) && room;
  assign grant = req && bus.imem_gnt;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;

  // ------------------------------------------------------ PC / tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        pc_q <= bus.redirect_pc & ~(XLEN'(3));
      end else if (grant) begin
        pc_q <= pc_q + XLEN'(4);
      end
      if (grant) begin
        req_pc_q      <= pc_q;
        outstanding_q <= 1'b1;
      end else if (bus.imem_rvalid) begin
        outstanding_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while count_q != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign bus.if_valid  = !fifo_empty;
  assign bus.if_instr  = fifo_empty ? NOP : fifo_instr[rd_ptr_q];
  assign bus.if_pc     = fifo_empty ? '0  : fifo_pc[rd_ptr_q];
  assign bus.if_opcode = bus.if_instr[6:0];

  // ------------------------------------------------------ perf counters
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (push)                           perf_fetched <= perf_fetched + 32'd1;
      if (bus.if_ready && fifo_empty)     perf_stall   <= perf_stall + 32'd1;
      if (bus.redirect_valid)             perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. A small memory responder
// grants every request (unless gnt_en is low) and answers one cycle later
// (unless hold is set) with mem_word(addr). Inputs change 1 time unit after
// the rising edge, outputs are sampled 2 units after it.
module tb_instr_fetch;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  // ---------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // responder / stimulus state
  logic        pend;
  logic [31:0] pend_addr;
  logic        hold;
  logic        gnt_en;
  logic        rdy;
  logic        rdr;
  logic [31:0] rdr_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------- driver
  // One clock cycle: book-keep the responder from the cycle just ending,
  // then apply this cycle's inputs and let the outputs settle.
  task automatic cyc();
    if (bus.imem_rvalid) pend = 1'b0;
    if (bus.imem_req && bus.imem_gnt) begin
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid    = pend && !hold;
    bus.imem_rdata     = (pend && !hold) ? mem_word(pend_addr) : 32'h0;
    bus.imem_gnt       = gnt_en;
    bus.if_ready       = rdy;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rdr_pc;
    #1;
  endtask

  task automatic hold_reset();
    rst    = 1'b1;
    gnt_en = 1'b1;
    rdy    = 1'b0;
    rdr    = 1'b0;
    rdr_pc = 32'h0;
    hold   = 1'b0;
    pend   = 1'b0;
    cyc();
    cyc();
    pend   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},    32'(bus.imem_req), 32'h0);
    check_eq({tag, "_addr"},   bus.imem_addr,     32'h0);
    check_eq({tag, "_valid"},  32'(bus.if_valid), 32'h0);
    check_eq({tag, "_instr"},  bus.if_instr,      32'h0000_0013);
    check_eq({tag, "_pc"},     bus.if_pc,         32'h0);
    check_eq({tag, "_opcode"}, 32'(bus.if_opcode), 32'h13);
    check_eq({tag, "_state"},  32'(dbg_state),    32'h0);
  endtask

  // ---------------------------------------------------- scenarios
  initial begin
    rst                = 1'b1;
    pend               = 1'b0;
    pend_addr          = 32'h0;
    hold               = 1'b0;
    gnt_en             = 1'b1;
    rdy                = 1'b0;
    rdr                = 1'b0;
    rdr_pc             = 32'h0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;

    // --- reset values, then streaming fetch with zero-wait memory
    hold_reset();
    check_reset_outputs("rst");
    rst = 1'b0;
    rdy = 1'b1;
    cyc();                                      // c0
    check_eq("s1_c0_req",   32'(bus.imem_req), 32'h1);
    check_eq("s1_c0_addr",  bus.imem_addr,     32'h0);
    check_eq("s1_c0_valid", 32'(bus.if_valid), 32'h0);
    check_eq("s1_c0_state", 32'(dbg_state),    32'h1);
    cyc();                                      // c1
    check_eq("s1_c1_addr",  bus.imem_addr,     32'h4);
    check_eq("s1_c1_valid", 32'(bus.if_valid), 32'h0);
    cyc();                                      // c2
    check_eq("s1_c2_addr",  bus.imem_addr,     32'h8);
    check_eq("s1_c2_valid", 32'(bus.if_valid), 32'h1);
    check_eq("s1_c2_pc",    bus.if_pc,         32'h0);
    check_eq("s1_c2_instr", bus.if_instr,      mem_word(32'h0));
    check_eq("s1_c2_opc",   32'(bus.if_opcode), 32'h13);
    cyc();                                      // c3
    check_eq("s1_c3_pc",    bus.if_pc,         32'h4);
    check_eq("s1_c3_addr",  bus.imem_addr,     32'hC);

    // --- decode stalls 6 cycles: FIFO fills to 2, requests stop
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();                                    // c4..c9
      check_eq($sformatf("s2_stall%0d_req", i), 32'(bus.imem_req), 32'h0);
      check_eq($sformatf("s2_stall%0d_pc", i),  bus.if_pc,         32'h8);
    end
    rdy = 1'b1;
    cyc();                                      // c10
    check_eq("s2_rel0_pc",   bus.if_pc,     32'h8);
    check_eq("s2_rel0_addr", bus.imem_addr, 32'h10);
    check_eq("s2_rel0_req",  32'(bus.imem_req), 32'h1);
    cyc();                                      // c11
    check_eq("s2_rel1_pc",   bus.if_pc,     32'hC);
    cyc();                                      // c12
    check_eq("s2_rel2_pc",    bus.if_pc,    32'h10);
    check_eq("s2_rel2_instr", bus.if_instr, mem_word(32'h10));

    // --- redirect while the 0x8 request is outstanding
    hold_reset();
    rst = 1'b0;
    rdy = 1'b1;
    cyc();                                      // c0 addr 0
    cyc();                                      // c1 addr 4
    cyc();                                      // c2 addr 8 granted
    check_eq("s3_c2_addr", bus.imem_addr, 32'h8);
    hold   = 1'b1;
    rdr    = 1'b1;
    rdr_pc = 32'h0000_0103;
    cyc();                                      // c3 redirect, 0x8 still out
    check_eq("s3_c3_req", 32'(bus.imem_req), 32'h0);
    hold = 1'b0;
    rdr  = 1'b0;
    cyc();                                      // c4 stale response returns
    check_eq("s3_c4_valid", 32'(bus.if_valid), 32'h0);
    check_eq("s3_c4_state", 32'(dbg_state),    32'h2);
    check_eq("s3_c4_req",   32'(bus.imem_req), 32'h1);
    check_eq("s3_c4_addr",  bus.imem_addr,     32'h100);
    cyc();                                      // c5
    check_eq("s3_c5_valid", 32'(bus.if_valid), 32'h0);
    check_eq("s3_c5_addr",  bus.imem_addr,     32'h104);
    cyc();                                      // c6
    check_eq("s3_c6_valid", 32'(bus.if_valid), 32'h1);
    check_eq("s3_c6_pc",    bus.if_pc,         32'h100);
    check_eq("s3_c6_instr", bus.if_instr,      mem_word(32'h100));

    // --- redirect to the top word (coincident response dropped), wrap to 0
    rdr    = 1'b1;
    rdr_pc = 32'hFFFF_FFFC;
    cyc();                                      // c7
    check_eq("s4_c7_req", 32'(bus.imem_req), 32'h0);
    rdr = 1'b0;
    cyc();                                      // c8
    check_eq("s4_c8_addr",  bus.imem_addr,     32'hFFFF_FFFC);
    check_eq("s4_c8_valid", 32'(bus.if_valid), 32'h0);
    check_eq("s4_c8_state", 32'(dbg_state),    32'h1);
    cyc();                                      // c9
    check_eq("s4_c9_addr",  bus.imem_addr,     32'h0);
    check_eq("s4_c9_valid", 32'(bus.if_valid), 32'h0);
    cyc();                                      // c10
    check_eq("s4_c10_pc",   bus.if_pc,          32'hFFFF_FFFC);
    check_eq("s4_c10_opc",  32'(bus.if_opcode), 32'h6F);
    cyc();                                      // c11
    check_eq("s4_c11_pc",   bus.if_pc,          32'h0);

    // --- fill the FIFO, then assert reset between clock edges
    rdy = 1'b0;
    repeat (4) cyc();
    check_eq("s5_full_valid", 32'(bus.if_valid), 32'h1);
    check_eq("s5_full_pc",    bus.if_pc,         32'h4);
    rst = 1'b1;
    #1;
    check_reset_outputs("s5_async");
    pend = 1'b0;
    cyc();
    rst = 1'b0;
    rdy = 1'b1;
    cyc();                                      // c0
    check_eq("s5_c0_req",  32'(bus.imem_req), 32'h1);
    check_eq("s5_c0_addr", bus.imem_addr,     32'h0);
    cyc();                                      // c1
    check_eq("s5_c1_addr", bus.imem_addr,     32'h4);
    cyc();                                      // c2
    check_eq("s5_c2_valid", 32'(bus.if_valid), 32'h1);
    check_eq("s5_c2_pc",    bus.if_pc,         32'h0);

`ifdef FETCH_PERF_CNT_EN
    // --- 10 words fetched and popped, 3 starved cycles, 1 redirect
    hold_reset();
    check_eq("s6_rst_fetched", perf_fetched, 32'd0);
    rst = 1'b0;
    cyc();                                      // c0, decode not ready
    for (int k = 1; k <= 13; k++) begin
      gnt_en = (k < 10);
      rdy    = 1'b1;
      cyc();                                    // c1..c13
    end
    rdy    = 1'b0;
    rdr    = 1'b1;
    rdr_pc = 32'h40;
    cyc();                                      // c14
    rdr = 1'b0;
    cyc();                                      // c15
    check_eq("s6_fetched", perf_fetched, 32'd10);
    check_eq("s6_stall",   perf_stall,   32'd3);
    check_eq("s6_flush",   perf_flush,   32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
